// File: rtl/morse_playback.sv
// Replays stored 10-bit morse symbols from the game RAM as timed pulses on led_out.
// The RAM is read-only here; each symbol is fetched, then shifted out element by element.
module morse_playback #(
    parameter int ADDR_W     = 5,
    parameter int DOT_TICKS  = 1,
    parameter int DASH_TICKS = 3,
    parameter int ELEM_GAP   = 1,
    parameter int SYM_GAP    = 3
) (
    input  logic              clock_1hz,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [9:0]        ram_q,
    output logic              led_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sym_index,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_ON      = 3'd3,
        S_GAP     = 3'd4,
        S_SYM_GAP = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        elem_cnt;
    logic [9:0]        shreg;
    logic [ADDR_W:0]   len_q;
    logic              last_sym;

    assign state_dbg = state;
    assign last_sym  = ({1'b0, sym_index} == (len_q - LEN_ONE));

    // On-time of an element minus one: bit 1 set means dash, otherwise dot.
    function automatic logic [CNT_W-1:0] elem_ticks(input logic [1:0] elem);
        return elem[1] ? CNT_W'(DASH_TICKS - 1) : CNT_W'(DOT_TICKS - 1);
    endfunction

    always_ff @(posedge clock_1hz) begin
        if (!resetn) begin
            state     <= S_IDLE;
            ram_addr  <= '0;
            sym_index <= '0;
            led_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            elem_cnt  <= '0;
            shreg     <= '0;
            len_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            len_q     <= length;
                            sym_index <= '0;
                            ram_addr  <= '0;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shreg    <= ram_q;
                    elem_cnt <= '0;
                    if (ram_q[9:8] == 2'b00) begin
                        cnt   <= CNT_W'(SYM_GAP - 1);
                        state <= S_SYM_GAP;
                    end else begin
                        led_out <= 1'b1;
                        cnt     <= elem_ticks(ram_q[9:8]);
                        state   <= S_ON;
                    end
                end
                S_ON: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        led_out  <= 1'b0;
                        shreg    <= {shreg[7:0], 2'b00};
                        elem_cnt <= elem_cnt + 3'd1;
                        // shreg[7:6] is the element that will sit on top after this shift.
                        if (elem_cnt == 3'd4 || shreg[7:6] == 2'b00) begin
                            cnt   <= CNT_W'(SYM_GAP - 1);
                            state <= S_SYM_GAP;
                        end else begin
                            cnt   <= CNT_W'(ELEM_GAP - 1);
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        led_out <= 1'b1;
                        cnt     <= elem_ticks(shreg[9:8]);
                        state   <= S_ON;
                    end
                end
                S_SYM_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (last_sym) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        sym_index <= sym_index + ADDR_ONE;
                        ram_addr  <= ram_addr + ADDR_ONE;
                        state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_playback.sv
// Bench for morse_playback: a timeline model expands each accepted request into the
// per-cycle outputs it must produce, and one process compares the DUT to it every cycle.
`timescale 1ns/1ps
module tb_morse_playback;

    localparam int DOT   = 1;
    localparam int DASH  = 3;
    localparam int EGAP  = 1;
    localparam int SGAP  = 3;

    logic       clock_1hz;
    logic       resetn;
    logic       start;
    logic [5:0] length;
    logic [4:0] ram_addr;
    logic [9:0] ram_q;
    logic       led_out;
    logic       busy;
    logic       done;
    logic [4:0] sym_index;
    logic [2:0] state_dbg;

    logic [9:0] mem [32];

    int checks;
    int errors;

    // Expected outputs per cycle: {led, busy, done, ram_addr, sym_index}
    logic [12:0] exp_q[$];
    logic [4:0]  m_addr;
    logic [4:0]  m_sym;

    morse_playback dut (
        .clock_1hz (clock_1hz),
        .resetn    (resetn),
        .start     (start),
        .length    (length),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .led_out   (led_out),
        .busy      (busy),
        .done      (done),
        .sym_index (sym_index),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock_1hz = 1'b0;
    always #5 clock_1hz = ~clock_1hz;

    // Synchronous-read RAM: data follows the address by one cycle.
    always @(posedge clock_1hz) ram_q <= mem[ram_addr];

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [12:0] pk(input logic l, input logic b, input logic d,
                                       input logic [4:0] a, input logic [4:0] s);
        return {l, b, d, a, s};
    endfunction

    task automatic build(input logic [5:0] len);
        logic [9:0] w;
        logic [1:0] el;
        logic [4:0] a;
        int n;
        if (len == 6'd0) begin
            exp_q.push_back(pk(1'b0, 1'b1, 1'b1, m_addr, m_sym));
            exp_q.push_back(pk(1'b0, 1'b0, 1'b0, m_addr, m_sym));
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            a = i[4:0];
            exp_q.push_back(pk(1'b0, 1'b1, 1'b0, a, a));
            exp_q.push_back(pk(1'b0, 1'b1, 1'b0, a, a));
            w = mem[i];
            n = 0;
            for (int e = 0; e < 5; e++) begin
                el = w[9-2*e -: 2];
                if (el == 2'b00) break;
                if (n > 0) repeat (EGAP) exp_q.push_back(pk(1'b0, 1'b1, 1'b0, a, a));
                repeat (el[1] ? DASH : DOT) exp_q.push_back(pk(1'b1, 1'b1, 1'b0, a, a));
                n++;
            end
            repeat (SGAP) exp_q.push_back(pk(1'b0, 1'b1, 1'b0, a, a));
        end
        a = 5'(len - 6'd1);
        exp_q.push_back(pk(1'b0, 1'b1, 1'b1, a, a));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, a, a));
        m_addr = a;
        m_sym  = a;
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(posedge clock_1hz) begin
        logic        r_s;
        logic        st_s;
        logic [5:0]  len_s;
        logic [12:0] expv;
        logic [12:0] gotv;
        r_s   = resetn;
        st_s  = start;
        len_s = length;
        #1;
        if (!r_s) begin
            exp_q.delete();
            m_addr = '0;
            m_sym  = '0;
            expv   = '0;
        end else begin
            if (exp_q.size() == 0 && st_s) build(len_s);
            if (exp_q.size() > 0) expv = exp_q.pop_front();
            else expv = pk(1'b0, 1'b0, 1'b0, m_addr, m_sym);
        end
        gotv = {led_out, busy, done, ram_addr, sym_index};
        checks++;
        if (gotv !== expv) begin
            errors++;
            $display("FAIL cycle t=%0t got led=%b busy=%b done=%b addr=%0d sym=%0d want led=%b busy=%b done=%b addr=%0d sym=%0d",
                     $time, gotv[12], gotv[11], gotv[10], gotv[9:5], gotv[4:0],
                     expv[12], expv[11], expv[10], expv[9:5], expv[4:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0) && k < budget) begin
            @(negedge clock_1hz);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles", budget);
        end
    endtask

    task automatic pulse_start(input logic [5:0] len);
        @(negedge clock_1hz);
        length = len;
        start  = 1'b1;
        @(negedge clock_1hz);
        start  = 1'b0;
        length = 6'($urandom_range(0, 32));
    endtask

    function automatic logic [9:0] rand_sym();
        logic [9:0] w;
        if ($urandom_range(0, 9) == 0) return 10'd0;
        w = 10'($urandom);
        return w;
    endfunction

    // ---------------- pins on the model itself ----------------
    task automatic pin_model();
        logic [11:0] ledv, donev, busyv;
        int hi;
        m_addr = '0;
        m_sym  = '0;
        mem[0] = 10'b01_11_00_00_00;
        exp_q.delete();
        build(6'd1);
        chk("pin_ex1_len", exp_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            ledv[11-i]  = exp_q[i][12];
            busyv[11-i] = exp_q[i][11];
            donev[11-i] = exp_q[i][10];
        end
        chk("pin_ex1_led", ledv, 12'b0010_1110_0000);
        chk("pin_ex1_done", donev, 12'b0000_0000_0010);
        chk("pin_ex1_busy", busyv, 12'b1111_1111_1110);
        exp_q.delete();
        m_addr = '0;
        m_sym  = '0;
        build(6'd0);
        chk("pin_len0_size", exp_q.size(), 2);
        chk("pin_len0_first", exp_q[0], 13'b0_1_1_00000_00000);
        exp_q.delete();
        mem[0] = 10'd0;
        build(6'd1);
        chk("pin_empty_size", exp_q.size(), 7);
        chk("pin_empty_done", exp_q[5], 13'b0_1_1_00000_00000);
        exp_q.delete();
        mem[0] = 10'b01_00_00_00_00;
        mem[1] = 10'b11_11_11_11_11;
        build(6'd2);
        chk("pin_ex2_size", exp_q.size(), 32);
        chk("pin_ex2_fetch1", exp_q[6], 13'b0_1_0_00001_00001);
        hi = 0;
        foreach (exp_q[i]) if (exp_q[i][12]) hi++;
        chk("pin_ex2_led_ticks", hi, 16);
        exp_q.delete();
        m_addr = '0;
        m_sym  = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lim;
        resetn = 1'b0;
        start  = 1'b0;
        length = '0;
        ram_q  = '0;
        checks = 0;
        errors = 0;
        foreach (mem[i]) mem[i] = '0;
        pin_model();

        repeat (3) @(negedge clock_1hz);
        resetn = 1'b1;
        repeat (6) @(negedge clock_1hz);
        chk("reset_idle", {led_out, busy, done, ram_addr}, 8'd0);

        // Spec example: dot then dash.
        mem[0] = 10'b01_11_00_00_00;
        pulse_start(6'd1);
        wait_idle(100);

        // Dot, then five dashes from address 1.
        mem[0] = 10'b01_00_00_00_00;
        mem[1] = 10'b11_11_11_11_11;
        pulse_start(6'd2);
        wait_idle(100);

        // Empty symbol, then zero-length request.
        mem[0] = 10'd0;
        pulse_start(6'd1);
        wait_idle(100);
        pulse_start(6'd0);
        wait_idle(100);

        // Reset during the second dash; check the abort and replay.
        mem[0] = 10'b11_11_00_00_00;
        @(negedge clock_1hz);
        length = 6'd1;
        start  = 1'b1;
        @(negedge clock_1hz);
        start  = 1'b0;
        repeat (6) @(negedge clock_1hz);
        chk("mid_dash_led", led_out, 1'b1);
        resetn = 1'b0;
        @(negedge clock_1hz);
        resetn = 1'b1;
        chk("abort_state", {led_out, busy, done}, 3'b000);
        pulse_start(6'd1);
        wait_idle(100);

        // Start held high through a playback with length noise.
        mem[0] = 10'b01_00_00_00_00;
        @(negedge clock_1hz);
        length = 6'd1;
        start  = 1'b1;
        repeat (14) begin
            @(negedge clock_1hz);
            length = 6'($urandom_range(0, 32));
        end
        start = 1'b0;
        wait_idle(200);

        // Randomized playbacks with start/length noise and occasional resets.
        for (int t = 0; t < 25; t++) begin
            int rst_at;
            foreach (mem[i]) mem[i] = rand_sym();
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 60)) : -1;
            pulse_start((t % 8 == 7) ? 6'd32 : 6'($urandom_range(0, 32)));
            lim = 0;
            while (exp_q.size() != 0 && lim < 2000) begin
                start  = ($urandom_range(0, 9) == 0);
                length = 6'($urandom_range(0, 32));
                resetn = (lim == rst_at) ? 1'b0 : 1'b1;
                @(negedge clock_1hz);
                lim++;
            end
            start  = 1'b0;
            resetn = 1'b1;
            wait_idle(2000);
            repeat ($urandom_range(1, 4)) @(negedge clock_1hz);
        end

        repeat (4) @(negedge clock_1hz);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
